// File: rtl/ip_rx_parser_if.sv
// Byte-stream bus between the EtherType demux, the IPv4 parser and the L4 decoders.
interface ip_rx_parser_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        hdr_valid;
  logic [31:0] sa;
  logic [31:0] da;
  logic [7:0]  protocol;
  logic [15:0] payload_len;
  logic        err;
  logic [3:0]  err_code;
  logic        done;

  modport master (
    output s_valid, s_data, s_last,
    input  m_valid, m_data, m_last, hdr_valid, sa, da, protocol, payload_len,
           err, err_code, done
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output m_valid, m_data, m_last, hdr_valid, sa, da, protocol, payload_len,
           err, err_code, done
  );
endinterface

// File: rtl/ip_rx_parser.sv
// IPv4 receive parser: validates the header, skips options, forwards payload, drops padding.
// state   | meaning
// HDR     | counting header bytes, checking fields and checksum
// PAYLOAD | forwarding payload bytes, cnt = bytes still owed
// PAD     | discarding Ethernet padding until s_last
// DROP    | discarding the rest of a rejected frame until s_last
module ip_rx_parser #(
  parameter logic [31:0] LOCAL_IP    = 32'hC0A800C7,
  parameter bit          FILTER_DA   = 1'b1,
  parameter bit          ACCEPT_UDP  = 1'b1,
  parameter bit          ACCEPT_TCP  = 1'b0,
  parameter bit          ACCEPT_ICMP = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  ip_rx_parser_if.slave bus
);

  localparam logic [1:0] S_HDR     = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_PAD     = 2'd2;
  localparam logic [1:0] S_DROP    = 2'd3;

  localparam logic [3:0] E_VERSION  = 4'd1;
  localparam logic [3:0] E_IHL      = 4'd2;
  localparam logic [3:0] E_LENGTH   = 4'd3;
  localparam logic [3:0] E_FRAG     = 4'd4;
  localparam logic [3:0] E_PROTO    = 4'd5;
  localparam logic [3:0] E_CHECKSUM = 4'd6;
  localparam logic [3:0] E_DEST     = 4'd7;
  localparam logic [3:0] E_TRUNC    = 4'd8;

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [7:0]  hdr_len;
  logic [15:0] tot_len;
  logic [15:0] csum;
  logic [7:0]  hi_byte;
  logic [7:0]  prot_sh;
  logic [63:0] addr_sh;

  logic [7:0]  b;
  logic [15:0] word;
  logic [16:0] sum_full;
  logic [15:0] csum_next;
  logic [63:0] addr_next;
  logic        hdr_last;
  logic [15:0] pl_next;
  logic        proto_ok;
  logic        da_ok;
  logic [3:0]  field_err;

  assign b         = bus.s_data;
  assign word      = {hi_byte, b};
  assign sum_full  = {1'b0, csum} + {1'b0, word};
  assign csum_next = sum_full[15:0] + {15'd0, sum_full[16]};
  assign addr_next = (cnt >= 16'd12 && cnt <= 16'd19) ? {addr_sh[55:0], b} : addr_sh;
  assign hdr_last  = (cnt == {8'd0, hdr_len} - 16'd1);
  assign pl_next   = tot_len - {8'd0, hdr_len};
  assign proto_ok  = ((b == 8'd17) && ACCEPT_UDP) || ((b == 8'd6) && ACCEPT_TCP) ||
                     ((b == 8'd1) && ACCEPT_ICMP);
  assign da_ok     = !FILTER_DA || (addr_next[31:0] == LOCAL_IP) ||
                     (addr_next[31:0] == 32'hFFFF_FFFF);

  // First failing check on the current header byte; field checks outrank truncation.
  always_comb begin
    field_err = 4'd0;
    case (cnt)
      16'd0: begin
        if (b[7:4] != 4'd4)     field_err = E_VERSION;
        else if (b[3:0] < 4'd5) field_err = E_IHL;
      end
      16'd3: if (word < {8'd0, hdr_len}) field_err = E_LENGTH;
      16'd7: if (hi_byte[5] || ({hi_byte[4:0], b} != 13'd0)) field_err = E_FRAG;
      16'd9: if (!proto_ok) field_err = E_PROTO;
      default: ;
    endcase
    if (field_err == 4'd0 && cnt == 16'd19 && !da_ok) field_err = E_DEST;
    if (field_err == 4'd0 && hdr_last && csum_next != 16'hFFFF) field_err = E_CHECKSUM;
    if (field_err == 4'd0 && bus.s_last && !(hdr_last && pl_next == 16'd0)) field_err = E_TRUNC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_HDR;
      cnt             <= 16'd0;
      hdr_len         <= 8'd0;
      tot_len         <= 16'd0;
      csum            <= 16'd0;
      hi_byte         <= 8'd0;
      prot_sh         <= 8'd0;
      addr_sh         <= 64'd0;
      bus.m_valid     <= 1'b0;
      bus.m_data      <= 8'd0;
      bus.m_last      <= 1'b0;
      bus.hdr_valid   <= 1'b0;
      bus.sa          <= 32'd0;
      bus.da          <= 32'd0;
      bus.protocol    <= 8'd0;
      bus.payload_len <= 16'd0;
      bus.err         <= 1'b0;
      bus.err_code    <= 4'd0;
      bus.done        <= 1'b0;
    end else begin
      bus.m_valid   <= 1'b0;
      bus.m_last    <= 1'b0;
      bus.hdr_valid <= 1'b0;
      bus.err       <= 1'b0;
      bus.err_code  <= 4'd0;
      bus.done      <= 1'b0;
      if (bus.s_valid) begin
        case (state)
          S_HDR: begin
            cnt     <= cnt + 16'd1;
            addr_sh <= addr_next;
            if (!cnt[0]) hi_byte <= b;
            else         csum    <= csum_next;
            if (cnt == 16'd0) hdr_len <= {2'b00, b[3:0], 2'b00};
            if (cnt == 16'd3) tot_len <= word;
            if (cnt == 16'd9) prot_sh <= b;
            if (field_err != 4'd0) begin
              bus.err      <= 1'b1;
              bus.err_code <= field_err;
              state        <= bus.s_last ? S_HDR : S_DROP;
              cnt          <= 16'd0;
              csum         <= 16'd0;
            end else if (hdr_last) begin
              bus.hdr_valid   <= 1'b1;
              bus.sa          <= addr_next[63:32];
              bus.da          <= addr_next[31:0];
              bus.protocol    <= prot_sh;
              bus.payload_len <= pl_next;
              csum            <= 16'd0;
              if (pl_next == 16'd0) begin
                bus.done <= 1'b1;
                state    <= bus.s_last ? S_HDR : S_PAD;
                cnt      <= 16'd0;
              end else begin
                state <= S_PAYLOAD;
                cnt   <= pl_next;
              end
            end
          end
          S_PAYLOAD: begin
            bus.m_valid <= 1'b1;
            bus.m_data  <= b;
            cnt         <= cnt - 16'd1;
            if (cnt == 16'd1) begin
              bus.m_last <= 1'b1;
              bus.done   <= 1'b1;
              state      <= bus.s_last ? S_HDR : S_PAD;
              cnt        <= 16'd0;
            end else if (bus.s_last) begin
              bus.m_last   <= 1'b1;
              bus.err      <= 1'b1;
              bus.err_code <= E_TRUNC;
              state        <= S_HDR;
              cnt          <= 16'd0;
            end
          end
          default: begin
            if (bus.s_last) begin
              state <= S_HDR;
              cnt   <= 16'd0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ip_rx_parser.sv
// Randomized bench for ip_rx_parser: a frame-level reference model predicts the outputs
// produced one cycle after every accepted byte; two DUTs differ only in ACCEPT_TCP.
module tb_ip_rx_parser;

  typedef struct {
    logic        mv;
    logic [7:0]  md;
    logic        ml;
    logic        hv;
    logic        er;
    logic [3:0]  ec;
    logic        dn;
    logic [31:0] sa;
    logic [31:0] da;
    logic [7:0]  pr;
    logic [15:0] pl;
  } exp_t;

  localparam logic [31:0] LOCAL_IP = 32'hC0A800C7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ip_rx_parser_if bus0 ();
  ip_rx_parser_if bus1 ();
  assign bus1.s_valid = bus0.s_valid;
  assign bus1.s_data  = bus0.s_data;
  assign bus1.s_last  = bus0.s_last;

  ip_rx_parser dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  ip_rx_parser #(.ACCEPT_TCP(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_total = 0, n_pass = 0, n_prints = 0;
  int n_mv = 0, n_done = 0, n_hdr = 0, n_err = 0, n_hdr1 = 0;
  logic [3:0] last_code = 4'd0;

  exp_t q0[$], q1[$];
  exp_t ch0, ch1, mh0, mh1;
  logic [7:0] fb[$];
  logic [7:0] sb[$];
  logic       sl[$];
  bit pend = 1'b0;

  function automatic exp_t zrec();
    exp_t z;
    z.mv = 0; z.md = 0; z.ml = 0; z.hv = 0; z.er = 0; z.ec = 0; z.dn = 0;
    z.sa = 0; z.da = 0; z.pr = 0; z.pl = 0;
    return z;
  endfunction

  function automatic exp_t grab0();
    exp_t a;
    a.mv = bus0.m_valid; a.md = bus0.m_data; a.ml = bus0.m_last; a.hv = bus0.hdr_valid;
    a.er = bus0.err; a.ec = bus0.err_code; a.dn = bus0.done; a.sa = bus0.sa; a.da = bus0.da;
    a.pr = bus0.protocol; a.pl = bus0.payload_len;
    return a;
  endfunction

  function automatic exp_t grab1();
    exp_t a;
    a.mv = bus1.m_valid; a.md = bus1.m_data; a.ml = bus1.m_last; a.hv = bus1.hdr_valid;
    a.er = bus1.err; a.ec = bus1.err_code; a.dn = bus1.done; a.sa = bus1.sa; a.da = bus1.da;
    a.pr = bus1.protocol; a.pl = bus1.payload_len;
    return a;
  endfunction

  function automatic bit same(exp_t e, exp_t a);
    return (e.mv === a.mv) && (!e.mv || e.md === a.md) && (e.ml === a.ml) &&
           (e.hv === a.hv) && (e.er === a.er) && (e.ec === a.ec) && (e.dn === a.dn) &&
           (e.sa === a.sa) && (e.da === a.da) && (e.pr === a.pr) && (e.pl === a.pl);
  endfunction

  task automatic check(input int d, input exp_t e, input exp_t a);
    n_total++;
    if (same(e, a)) n_pass++;
    else begin
      n_prints++;
      if (n_prints <= 20)
        $display("FAIL cycle_dut%0d t=%0t got mv=%b md=%h ml=%b hv=%b er=%b ec=%0d dn=%b sa=%h da=%h pr=%h pl=%0d want mv=%b md=%h ml=%b hv=%b er=%b ec=%0d dn=%b sa=%h da=%h pr=%h pl=%0d",
                 d, $time, a.mv, a.md, a.ml, a.hv, a.er, a.ec, a.dn, a.sa, a.da, a.pr, a.pl,
                 e.mv, e.md, e.ml, e.hv, e.er, e.ec, e.dn, e.sa, e.da, e.pr, e.pl);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s got %h want %h", nm, act, want);
  endtask

  // Compare process: outputs must follow each accepted byte by exactly one cycle.
  always @(negedge clk) begin
    exp_t e, a;
    a = grab0();
    e = ch0;
    if (pend) begin
      if (q0.size() == 0) begin n_total++; $display("FAIL dut0_underflow t=%0t got empty want record", $time); end
      else begin e = q0.pop_front(); ch0 = e; ch0.mv = 0; ch0.ml = 0; ch0.hv = 0; ch0.er = 0; ch0.ec = 0; ch0.dn = 0; end
    end
    check(0, e, a);
    if (a.mv) n_mv++;
    if (a.dn) n_done++;
    if (a.hv) n_hdr++;
    if (a.er) begin n_err++; last_code = a.ec; end
    a = grab1();
    e = ch1;
    if (pend) begin
      if (q1.size() == 0) begin n_total++; $display("FAIL dut1_underflow t=%0t got empty want record", $time); end
      else begin e = q1.pop_front(); ch1 = e; ch1.mv = 0; ch1.ml = 0; ch1.hv = 0; ch1.er = 0; ch1.ec = 0; ch1.dn = 0; end
    end
    check(1, e, a);
    if (a.hv) n_hdr1++;
    pend = bus0.s_valid && rst_n;
  end

  task automatic build(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] tl,
                       input logic [15:0] frag, input logic [7:0] proto, input logic [31:0] sa_v,
                       input logic [31:0] da_v, input bit bad_cs, input int npay, input bit seq);
    int hlb, sum;
    logic [15:0] id, cs;
    hlb = (ihl >= 4'd5) ? 4 * int'(ihl) : 20;
    id = seq ? 16'd0 : 16'($urandom_range(0, 65535));
    fb.delete();
    fb.push_back({ver, ihl}); fb.push_back(8'h00); fb.push_back(tl[15:8]); fb.push_back(tl[7:0]);
    fb.push_back(id[15:8]); fb.push_back(id[7:0]); fb.push_back(frag[15:8]); fb.push_back(frag[7:0]);
    fb.push_back(8'h40); fb.push_back(proto); fb.push_back(8'h00); fb.push_back(8'h00);
    for (int j = 3; j >= 0; j--) fb.push_back(sa_v[8*j +: 8]);
    for (int j = 3; j >= 0; j--) fb.push_back(da_v[8*j +: 8]);
    for (int j = 20; j < hlb; j++) fb.push_back(seq ? 8'h00 : 8'($urandom_range(0, 255)));
    sum = 0;
    for (int j = 0; j < hlb; j += 2) sum += int'({fb[j], fb[j+1]});
    while (sum > 65535) sum = (sum % 65536) + (sum / 65536);
    cs = ~sum[15:0];
    if (bad_cs) cs = cs ^ 16'h0001;
    fb[10] = cs[15:8];
    fb[11] = cs[7:0];
    for (int j = 0; j < npay; j++) fb.push_back(seq ? 8'(j) : 8'($urandom_range(0, 255)));
  endtask

  // Reference: find the first rule the frame breaks, then emit one record per byte.
  task automatic model_frame(input bit tcp);
    exp_t h, r;
    int n, hl, tl, pl, erri, sum;
    logic [3:0] ec, code;
    logic [31:0] dav;
    h = tcp ? mh1 : mh0;
    n = fb.size();
    hl = 4 * int'(fb[0][3:0]);
    tl = (n > 3) ? int'({fb[2], fb[3]}) : 0;
    erri = -1;
    ec = 0;
    for (int i = 0; i < n && erri < 0 && (i == 0 || i < hl); i++) begin
      code = 0;
      if (i == 0) begin
        if (fb[0][7:4] != 4'd4) code = 1;
        else if (fb[0][3:0] < 4'd5) code = 2;
      end else if (i == 3 && tl < hl) code = 3;
      else if (i == 7 && (fb[6][5] || {fb[6][4:0], fb[7]} != 13'd0)) code = 4;
      else if (i == 9 && !(fb[9] == 8'd17 || (tcp && fb[9] == 8'd6))) code = 5;
      if (code == 0 && i == 19) begin
        dav = {fb[16], fb[17], fb[18], fb[19]};
        if (dav != LOCAL_IP && dav != 32'hFFFF_FFFF) code = 7;
      end
      if (code == 0 && i == hl - 1) begin
        sum = 0;
        for (int j = 0; j < hl; j += 2) sum += int'({fb[j], fb[j+1]});
        while (sum > 65535) sum = (sum % 65536) + (sum / 65536);
        if (sum != 65535) code = 6;
      end
      if (code == 0 && i == n - 1 && (i < hl - 1 || tl != hl)) code = 8;
      if (code != 0) begin erri = i; ec = code; end
    end
    pl = tl - hl;
    for (int i = 0; i < n; i++) begin
      r = h;
      if (erri >= 0) begin
        if (i == erri) begin r.er = 1; r.ec = ec; end
      end else if (i == hl - 1) begin
        h.sa = {fb[12], fb[13], fb[14], fb[15]};
        h.da = {fb[16], fb[17], fb[18], fb[19]};
        h.pr = fb[9];
        h.pl = pl[15:0];
        r = h;
        r.hv = 1;
        r.dn = (pl == 0);
      end else if (i >= hl && i < hl + pl) begin
        r.mv = 1;
        r.md = fb[i];
        if (i == hl + pl - 1) begin r.ml = 1; r.dn = 1; end
        else if (i == n - 1) begin r.ml = 1; r.er = 1; r.ec = 8; end
      end
      if (tcp) q1.push_back(r); else q0.push_back(r);
    end
    if (tcp) mh1 = h; else mh0 = h;
  endtask

  task automatic add_frame();
    model_frame(1'b0);
    model_frame(1'b1);
    for (int i = 0; i < fb.size(); i++) begin
      sb.push_back(fb[i]);
      sl.push_back(i == fb.size() - 1);
    end
  endtask

  task automatic drive_stream(input int gm);
    while (sb.size() > 0) begin
      if (gm == 1 || (gm == 2 && $urandom_range(0, 3) == 0)) begin
        bus0.s_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus0.s_valid = 1'b1;
      bus0.s_data  = sb.pop_front();
      bus0.s_last  = sl.pop_front();
      @(posedge clk); #1;
    end
    bus0.s_valid = 1'b0;
    bus0.s_last  = 1'b0;
  endtask

  task automatic settle_and_clear();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n_mv = 0; n_done = 0; n_hdr = 0; n_err = 0; n_hdr1 = 0; last_code = 0;
  endtask

  task automatic frame1(input int npay);
    build(4'd4, 4'd5, 16'h0073, 16'h4000, 8'h11, 32'hC0A80001, LOCAL_IP, 1'b0, npay, 1'b1);
  endtask

  initial begin
    int r, hlb, pl, npay;
    logic [3:0] ver, ihl;
    logic [15:0] tl, frag;
    logic [7:0] proto;
    logic [31:0] dav;
    ch0 = zrec(); ch1 = zrec(); mh0 = zrec(); mh1 = zrec();
    bus0.s_valid = 1'b0; bus0.s_data = 8'h00; bus0.s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    settle_and_clear();

    frame1(95);
    lit("frame1_checksum", {16'h0, fb[10], fb[11]}, 32'h0000B861);
    clear_stats(); add_frame(); drive_stream(0); settle_and_clear();
    lit("s1_hdr_valid", n_hdr, 1);
    lit("s1_sa", bus0.sa, 32'hC0A80001);
    lit("s1_da", bus0.da, 32'hC0A800C7);
    lit("s1_protocol", {24'h0, bus0.protocol}, 32'h11);
    lit("s1_payload_len", {16'h0, bus0.payload_len}, 95);
    lit("s1_mvalid_count", n_mv, 95);
    lit("s1_done_count", n_done, 1);

    frame1(95);
    fb[11] = 8'h62;
    clear_stats(); add_frame(); drive_stream(0); settle_and_clear();
    lit("s2_err_count", n_err, 1);
    lit("s2_err_code", {28'h0, last_code}, 6);
    lit("s2_no_hdr", n_hdr, 0);
    lit("s2_no_mvalid", n_mv, 0);

    build(4'd4, 4'd6, 16'h0077, 16'h4000, 8'h11, 32'hC0A80001, LOCAL_IP, 1'b0, 99, 1'b1);
    clear_stats(); add_frame(); drive_stream(0); settle_and_clear();
    lit("s3_hdr_valid", n_hdr, 1);
    lit("s3_mvalid_count", n_mv, 95);
    lit("s3_done_count", n_done, 1);

    build(4'd4, 4'd5, 16'h0073, 16'h4000, 8'h06, 32'hC0A80001, LOCAL_IP, 1'b0, 95, 1'b1);
    clear_stats(); add_frame(); drive_stream(0); settle_and_clear();
    lit("s4_err_code", {28'h0, last_code}, 5);
    lit("s4_no_hdr", n_hdr, 0);
    lit("s4_tcp_accept", n_hdr1, 1);

    frame1(41);
    add_frame();
    clear_stats();
    frame1(95);
    add_frame(); drive_stream(0); settle_and_clear();
    lit("s5_mvalid_count", n_mv, 41 + 95);
    lit("s5_err_code", {28'h0, last_code}, 8);
    lit("s5_done_once", n_done, 1);
    lit("s5_hdr_twice", n_hdr, 2);

    frame1(95);
    clear_stats(); add_frame(); drive_stream(1); settle_and_clear();
    lit("s6_mvalid_count", n_mv, 95);
    lit("s6_done_count", n_done, 1);

    for (int k = 0; k < 160; k++) begin
      r = $urandom_range(0, 99);
      ver = (r < 4) ? 4'($urandom_range(0, 15)) : 4'd4;
      ihl = (r >= 4 && r < 8) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 7));
      hlb = (ihl >= 4'd5) ? 4 * int'(ihl) : 20;
      pl = $urandom_range(0, 24);
      tl = 16'(hlb + pl);
      if (r >= 8 && r < 12) tl = 16'($urandom_range(0, hlb - 1));
      if (r >= 12 && r < 16) frag = $urandom_range(0, 1) ? 16'h2000 : 16'(1 + $urandom_range(0, 8190));
      else frag = $urandom_range(0, 1) ? 16'h4000 : 16'h0000;
      case ($urandom_range(0, 4))
        0, 1: proto = 8'd17;
        2: proto = 8'd6;
        3: proto = 8'd1;
        default: proto = 8'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 3))
        0, 1: dav = LOCAL_IP;
        2: dav = 32'hFFFF_FFFF;
        default: dav = $urandom;
      endcase
      npay = pl + $urandom_range(0, 4);
      if (r >= 22 && r < 28) npay = (pl > 0) ? $urandom_range(0, pl - 1) : 0;
      build(ver, ihl, tl, frag, proto, $urandom, dav, (r >= 16 && r < 22), npay, 1'b0);
      if (r >= 28 && r < 32) begin
        hlb = $urandom_range(1, hlb - 1);
        while (fb.size() > hlb) void'(fb.pop_back());
      end
      add_frame();
      drive_stream(2 * $urandom_range(0, 1));
    end
    settle_and_clear();
    lit("q0_drained", 32'(q0.size()), 0);
    lit("q1_drained", 32'(q1.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
